pll_dig_loop_ctrl: RTL
======================

// Module: pll_dig_loop_ctrl
// PURPOSE
//  Synthesizable digital loop controller for the next-generation PLL. It runs on the reference clock.
//  Two-phase acquisition:
//   - frequency acquisition from a per-reference-period DCO edge count;
//   - bang-bang phase tracking with a saturating PI update.
//  Lock detection with hysteresis. Drives the DCO control code. Sits between the feedback counter/PD and the DCO.
// PARAMETERS
//  CODE_W     10   DCO code width; code range 0..2^CODE_W-1 (higher code = faster DCO)
//  CNT_W      8    width of div_n and fb_cnt
//  INIT_CODE  512  dco_code in reset/IDLE
//  KF         4    frequency-acquisition gain (code LSB per count of error)
//  KP         2    proportional phase gain
//  KI         1    integral phase gain
//  INT_W      12   signed phase integrator width
//  FTOL       1    |ferr| <= FTOL counts as frequency-locked sample
//  FLOCK_CNT  4    consecutive in-tolerance samples to leave FREQ_ACQ
//  RELOCK_TOL 4    |ferr| > RELOCK_TOL in tracking = loss of lock
//  LOCK_WIN   64   lock-evaluation window, cycles (power of 2)
// PORTS
//  clk          in   1      reference clock
//  rst          in   1      synchronous, active-high reset
//  enable       in   1      loop enable
//  div_n        in   CNT_W  target DCO cycles per reference period
//  fb_cnt       in   CNT_W  measured DCO cycles in last reference period
//  fb_cnt_valid in   1      fb_cnt qualifier, one-cycle pulse
//  pd_early     in   1      bang-bang PD: 1 = feedback edge early (DCO fast)
//  dco_code     out  CODE_W DCO control code (registered)
//  locked       out  1      1 iff state==LOCKED
//  state        out  2      IDLE=0 FREQ_ACQ=1 PHASE_TRK=2 LOCKED=3
//  code_sat     out  1      high the cycle after any dco_code clamp
// BEHAVIOUR
//  Reset: dco_code=INIT_CODE, state=IDLE, locked=0, code_sat=0, integrator/counters=0.
//   rst has top priority; it is honoured mid-operation.
//  Priority each cycle: rst > !enable (->IDLE, dco_code=INIT_CODE next cycle) > loss-of-lock > window evaluation.
//  All outputs are registered. An input sampled at edge k is reflected at edge k+1.
//  IDLE: hold INIT_CODE. When enable=1, go to FREQ_ACQ.
//  FREQ_ACQ: on fb_cnt_valid compute ferr = div_n - fb_cnt (signed CNT_W+1 bits).
//   - dco_code <= clamp(dco_code + KF*ferr, 0, 2^CODE_W-1), computed wide enough to avoid overflow.
//   - In-tolerance counter increments if |ferr| <= FTOL; otherwise it clears.
//   - On reaching FLOCK_CNT: go to PHASE_TRK. base <= updated code; integ <= 0; window/toggle counters <= 0.
//   - Cycles without fb_cnt_valid leave everything unchanged.
//  PHASE_TRK/LOCKED: every cycle e = pd_early ? -1 : +1.
//   - integ <= sat(integ + KI*e) to signed INT_W range.
//   - dco_code <= clamp(base + integ_next + KP*e).
//   - Toggle counter increments when pd_early differs from the previous cycle's sample. The first sample after entry does not count.
//   - Window counter wraps every LOCK_WIN cycles. At wrap the toggle counter is evaluated, then cleared:
//     - PHASE_TRK -> LOCKED if toggles >= LOCK_WIN/4;
//     - LOCKED -> PHASE_TRK if toggles < LOCK_WIN/8 (hysteresis); otherwise stay.
//   - Loss of lock: fb_cnt_valid with |ferr| > RELOCK_TOL.
//     - State goes to FREQ_ACQ, locked=0 next cycle, integ and in-tolerance counter cleared.
//     - dco_code applies the FREQ_ACQ update for that sample. This overrides a window wrap in the same cycle.
//   - fb_cnt_valid within tolerance is ignored in tracking.
//  Clamp: any clamp of dco_code (low or high) sets code_sat=1 the next cycle, else 0. Integrator saturation does not set code_sat.
//  div_n changes take effect on the next fb_cnt_valid. No other restart occurs.
// TESTING
//  1. rst=1 for 2 cycles -> dco_code=512, state=0, locked=0, code_sat=0.
//  2. enable=1, div_n=30; fb_cnt=20 valid -> dco_code=552.
//     Then fb_cnt=30 valid x4 -> state=2 after 4th sample, base=552.
//  3. dco_code=1000, div_n=255, fb_cnt=0 valid -> dco_code=1023, code_sat=1 next cycle.
//     Then fb_cnt=255 valid -> code_sat=0.
//  4. PHASE_TRK with base=600: pd_early=1 for 3 cycles -> dco_code 597, 596, 595.
//     Then pd_early alternating for a full window -> locked=1 the cycle after wrap.
//  5. LOCKED, div_n=30, fb_cnt=35 valid, coinciding with a window wrap -> state=1, locked=0, integ=0.
//     dco_code = previous - 20.
//  6. enable=0 during FREQ_ACQ -> state=0, dco_code=512 next cycle.
//     Separately, rst=1 in LOCKED -> same as test 1.

Source files
------------

// File: rtl/pll_dig_loop_ctrl.sv
// PLL digital loop controller: frequency acquisition from DCO edge counts, then bang-bang PI phase tracking with lock detection.
// One-cycle latency (all outputs registered); no backpressure, runs every reference cycle.
module pll_dig_loop_ctrl #(
    parameter int CODE_W     = 10,
    parameter int CNT_W      = 8,
    parameter int INIT_CODE  = 512,
    parameter int KF         = 4,
    parameter int KP         = 2,
    parameter int KI         = 1,
    parameter int INT_W      = 12,
    parameter int FTOL       = 1,
    parameter int FLOCK_CNT  = 4,
    parameter int RELOCK_TOL = 4,
    parameter int LOCK_WIN   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  div_n,
    input  logic [CNT_W-1:0]  fb_cnt,
    input  logic              fb_cnt_valid,
    input  logic              pd_early,
    output logic [CODE_W-1:0] dco_code,
    output logic              locked,
    output logic [1:0]        state,
    output logic              code_sat
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FREQ_ACQ  = 2'd1,
        PHASE_TRK = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    localparam int SW    = CODE_W + INT_W + CNT_W + 4;
    localparam int WIN_W = $clog2(LOCK_WIN);
    localparam int TOL_W = $clog2(FLOCK_CNT + 1);

    localparam logic signed [SW-1:0] CODE_MAX = SW'(2**CODE_W - 1);
    localparam logic signed [SW-1:0] INT_MAX  = SW'(2**(INT_W-1) - 1);
    localparam logic signed [SW-1:0] INT_MIN  = SW'(-(2**(INT_W-1)));

    state_t                   state_q, state_nxt;
    logic [CODE_W-1:0]        code_q, code_nxt;
    logic                     sat_q, sat_nxt;
    logic                     locked_q;
    logic [CODE_W-1:0]        base_q, base_nxt;
    logic signed [INT_W-1:0]  integ_q, integ_nxt;
    logic [TOL_W-1:0]         tol_q, tol_nxt;
    logic [WIN_W-1:0]         win_q, win_nxt;
    logic [WIN_W:0]           tog_q, tog_nxt;
    logic                     prev_pd_q, prev_pd_nxt;
    logic                     prev_vld_q, prev_vld_nxt;

    logic signed [CNT_W:0]    ferr;
    logic [CNT_W:0]           ferr_mag;
    logic                     in_tol;
    logic                     lose_lock;
    logic signed [SW-1:0]     facq_sum;
    logic signed [SW-1:0]     e_s;
    logic signed [SW-1:0]     integ_sum;
    logic signed [SW-1:0]     integ_clip;
    logic signed [INT_W-1:0]  integ_trk;
    logic signed [SW-1:0]     trk_sum;
    logic [CODE_W-1:0]        facq_code, trk_code;
    logic                     facq_sat, trk_sat;
    logic [TOL_W-1:0]         tol_inc;
    logic                     tog_inc;
    logic [WIN_W:0]           tog_eval;
    logic                     wrap;

    // Returns {clamped_flag, code}; sign bit catches negative sums.
    function automatic logic [CODE_W:0] clamp_code(input logic signed [SW-1:0] v);
        if (v[SW-1])
            return {1'b1, {CODE_W{1'b0}}};
        else if (v > CODE_MAX)
            return {1'b1, {CODE_W{1'b1}}};
        else
            return {1'b0, v[CODE_W-1:0]};
    endfunction

    assign ferr      = $signed({1'b0, div_n}) - $signed({1'b0, fb_cnt});
    assign ferr_mag  = ferr[CNT_W] ? $unsigned(-ferr) : $unsigned(ferr);
    assign in_tol    = ferr_mag <= (CNT_W+1)'(FTOL);
    assign lose_lock = fb_cnt_valid && (ferr_mag > (CNT_W+1)'(RELOCK_TOL));

    assign facq_sum   = $signed(SW'({1'b0, code_q})) + SW'(ferr) * SW'(KF);
    assign e_s        = pd_early ? {SW{1'b1}} : SW'(1);
    assign integ_sum  = SW'(integ_q) + SW'(KI) * e_s;
    assign integ_clip = (integ_sum > INT_MAX) ? INT_MAX :
                        (integ_sum < INT_MIN) ? INT_MIN : integ_sum;
    assign integ_trk  = INT_W'(integ_clip);
    assign trk_sum    = $signed(SW'({1'b0, base_q})) + SW'(integ_trk) + SW'(KP) * e_s;

    assign {facq_sat, facq_code} = clamp_code(facq_sum);
    assign {trk_sat, trk_code}   = clamp_code(trk_sum);

    assign tol_inc  = tol_q + 1'b1;
    assign tog_inc  = prev_vld_q && (pd_early != prev_pd_q);
    assign tog_eval = tog_q + (WIN_W+1)'(tog_inc);
    assign wrap     = win_q == WIN_W'(LOCK_WIN - 1);

    always_comb begin
        state_nxt    = state_q;
        code_nxt     = code_q;
        sat_nxt      = 1'b0;
        base_nxt     = base_q;
        integ_nxt    = integ_q;
        tol_nxt      = tol_q;
        win_nxt      = win_q;
        tog_nxt      = tog_q;
        prev_pd_nxt  = prev_pd_q;
        prev_vld_nxt = prev_vld_q;

        if (!enable) begin
            state_nxt    = IDLE;
            code_nxt     = CODE_W'(INIT_CODE);
            integ_nxt    = '0;
            tol_nxt      = '0;
            win_nxt      = '0;
            tog_nxt      = '0;
            prev_vld_nxt = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_nxt = FREQ_ACQ;
                FREQ_ACQ: begin
                    if (fb_cnt_valid) begin
                        code_nxt = facq_code;
                        sat_nxt  = facq_sat;
                        if (!in_tol) begin
                            tol_nxt = '0;
                        end else if (tol_inc == TOL_W'(FLOCK_CNT)) begin
                            state_nxt    = PHASE_TRK;
                            tol_nxt      = '0;
                            base_nxt     = facq_code;
                            integ_nxt    = '0;
                            win_nxt      = '0;
                            tog_nxt      = '0;
                            prev_vld_nxt = 1'b0;
                        end else begin
                            tol_nxt = tol_inc;
                        end
                    end
                end
                PHASE_TRK, LOCKED: begin
                    // Loss of lock pre-empts the window evaluation in the same cycle.
                    if (lose_lock) begin
                        state_nxt = FREQ_ACQ;
                        code_nxt  = facq_code;
                        sat_nxt   = facq_sat;
                        integ_nxt = '0;
                        tol_nxt   = '0;
                    end else begin
                        integ_nxt    = integ_trk;
                        code_nxt     = trk_code;
                        sat_nxt      = trk_sat;
                        prev_pd_nxt  = pd_early;
                        prev_vld_nxt = 1'b1;
                        win_nxt      = win_q + 1'b1;
                        tog_nxt      = tog_eval;
                        if (wrap) begin
                            tog_nxt = '0;
                            if (state_q == PHASE_TRK && tog_eval >= (WIN_W+1)'(LOCK_WIN/4))
                                state_nxt = LOCKED;
                            else if (state_q == LOCKED && tog_eval < (WIN_W+1)'(LOCK_WIN/8))
                                state_nxt = PHASE_TRK;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= CODE_W'(INIT_CODE);
            sat_q      <= 1'b0;
            locked_q   <= 1'b0;
            base_q     <= '0;
            integ_q    <= '0;
            tol_q      <= '0;
            win_q      <= '0;
            tog_q      <= '0;
            prev_pd_q  <= 1'b0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            code_q     <= code_nxt;
            sat_q      <= sat_nxt;
            locked_q   <= (state_nxt == LOCKED);
            base_q     <= base_nxt;
            integ_q    <= integ_nxt;
            tol_q      <= tol_nxt;
            win_q      <= win_nxt;
            tog_q      <= tog_nxt;
            prev_pd_q  <= prev_pd_nxt;
            prev_vld_q <= prev_vld_nxt;
        end
    end

    assign dco_code = code_q;
    assign locked   = locked_q;
    assign state    = state_q;
    assign code_sat = sat_q;

endmodule
